pong_game_fsm: RTL and testbench

// Game sequencer for the pong display. Owns ball position/direction, serve/point/game-over

---
 rtl/pong_pkg.sv | 37 +++
 rtl/pong_frame_ticker.sv | 56 +++++
 rtl/pong_game_fsm.sv | 194 +++++++++++++++++++
 tb/tb_pong_game_fsm.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared types and grid constants for the pong game sequencer.
// The 40x30 grid is addressed with 6-bit columns and 5-bit rows.
package pong_pkg;

    localparam int GRID_COLS = 40;
    localparam int GRID_ROWS = 30;
    localparam int X_W       = 6;
    localparam int Y_W       = 5;
    localparam int SCORE_W   = 4;

    localparam logic [X_W-1:0] CENTRE_X = 6'd20;
    localparam logic [Y_W-1:0] CENTRE_Y = 5'd15;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        POINT    = 3'd3,
        GAMEOVER = 3'd4
    } game_state_t;

    // Paddle span is widened to 6 bits so top+len cannot wrap; off-grid rows simply never match.
    function automatic logic paddle_covers(
        input logic [Y_W-1:0] row,
        input logic [Y_W-1:0] top,
        input logic [X_W-1:0] len
    );
        logic [X_W-1:0] row_w;
        logic [X_W-1:0] lo_w;
        logic [X_W-1:0] hi_w;
        row_w = X_W'(row);
        lo_w  = X_W'(top);
        hi_w  = lo_w + len - 6'd1;
        return (row_w >= lo_w) && (row_w <= hi_w);
    endfunction

endpackage

// File: rtl/pong_frame_ticker.sv
// Frame timing for the game sequencer: vsync falling-edge tick, ball-speed divider
// and the hold counter used by SERVE/POINT. Both counters restart whenever the state changes.
module pong_frame_ticker
    import pong_pkg::*;
#(
    parameter int SPEED_DIV   = 4,
    parameter int HOLD_FRAMES = 60
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        vsync_i,
    input  game_state_t state_i,
    output logic        frame_tick_o,
    output logic        move_tick_o,
    output logic        hold_done_o
);

    localparam int                HOLD_W    = (HOLD_FRAMES > 2) ? $clog2(HOLD_FRAMES) : 1;
    localparam logic [3:0]        DIV_LAST  = 4'(SPEED_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);

    logic              vsync_q;
    logic              frame_tick_q;
    logic [3:0]        div_q;
    logic [HOLD_W-1:0] hold_q;
    game_state_t       state_seen_q;

    // Edge detect plus counters; a state change is seen one cycle after the tick that caused it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
            div_q        <= 4'd0;
            hold_q       <= '0;
            state_seen_q <= IDLE;
        end else begin
            vsync_q      <= vsync_i;
            frame_tick_q <= vsync_q & ~vsync_i;
            if (state_i != state_seen_q) begin
                state_seen_q <= state_i;
                div_q        <= 4'd0;
                hold_q       <= '0;
            end else if (frame_tick_q) begin
                div_q <= (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
                if (hold_q != HOLD_LAST) begin
                    hold_q <= hold_q + 1'b1;
                end
            end
        end
    end

    assign frame_tick_o = frame_tick_q;
    assign move_tick_o  = frame_tick_q && (div_q == DIV_LAST);
    assign hold_done_o  = frame_tick_q && (hold_q == HOLD_LAST);

endmodule

// File: rtl/pong_game_fsm.sv
// Pong game sequencer: serve/play/point/game-over FSM, ball motion with wall and
// paddle reflection, scoring, and the ball pixel flag for the colour mux.
module pong_game_fsm
    import pong_pkg::*;
#(
    parameter int L_COL       = 0,
    parameter int COLS        = GRID_COLS,
    parameter int R_COL       = COLS - 1,
    parameter int ROWS        = GRID_ROWS,
    parameter int PADDLE_LEN  = 4,
    parameter int SPEED_DIV   = 4,
    parameter int HOLD_FRAMES = 60,
    parameter int WIN_SCORE   = 9
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               vsync,
    input  logic               serve_btn,
    input  logic [Y_W-1:0]     paddle_l_top,
    input  logic [Y_W-1:0]     paddle_r_top,
    input  logic [X_W-1:0]     hori_grid,
    input  logic [Y_W-1:0]     vert_grid,
    output logic [X_W-1:0]     ball_x,
    output logic [Y_W-1:0]     ball_y,
    output logic               ball_on,
    output logic [SCORE_W-1:0] score_l,
    output logic [SCORE_W-1:0] score_r,
    output logic [2:0]         game_state
);

    localparam logic [X_W-1:0]     L_HIT_X  = X_W'(L_COL + 1);
    localparam logic [X_W-1:0]     R_HIT_X  = X_W'(R_COL - 1);
    localparam logic [Y_W-1:0]     ROW_LAST = Y_W'(ROWS - 1);
    localparam logic [X_W-1:0]     PAD_LEN  = X_W'(PADDLE_LEN);
    localparam logic [SCORE_W-1:0] WIN      = SCORE_W'(WIN_SCORE);

    game_state_t        state_q;
    logic [X_W-1:0]     x_q;
    logic [Y_W-1:0]     y_q;
    logic               dx_neg_q;
    logic               dy_neg_q;
    logic               serve_left_q;
    logic [SCORE_W-1:0] score_l_q;
    logic [SCORE_W-1:0] score_r_q;

    logic               frame_tick_s;
    logic               move_tick_s;
    logic               hold_done_s;
    logic               step_dx_neg_s;
    logic               step_dy_neg_s;
    logic [X_W-1:0]     step_x_s;
    logic [Y_W-1:0]     step_y_s;
    logic               miss_l_s;
    logic               miss_r_s;
    logic               win_reached_s;

    pong_frame_ticker #(
        .SPEED_DIV   (SPEED_DIV),
        .HOLD_FRAMES (HOLD_FRAMES)
    ) u_ticker (
        .clk          (clk),
        .rst_n        (reset),
        .vsync_i      (vsync),
        .state_i      (state_q),
        .frame_tick_o (frame_tick_s),
        .move_tick_o  (move_tick_s),
        .hold_done_o  (hold_done_s)
    );

    // One ball step: wall reflection first, so the paddle test sees the already-reflected row.
    always_comb begin
        step_dy_neg_s = dy_neg_q;
        if ((y_q == 5'd0) && dy_neg_q) begin
            step_dy_neg_s = 1'b0;
        end else if ((y_q == ROW_LAST) && !dy_neg_q) begin
            step_dy_neg_s = 1'b1;
        end else begin
            step_dy_neg_s = dy_neg_q;
        end
        step_y_s      = step_dy_neg_s ? (y_q - 5'd1) : (y_q + 5'd1);
        step_dx_neg_s = dx_neg_q;
        step_x_s      = dx_neg_q ? (x_q - 6'd1) : (x_q + 6'd1);
        miss_l_s      = 1'b0;
        miss_r_s      = 1'b0;
        if (dx_neg_q && (x_q == L_HIT_X)) begin
            if (paddle_covers(step_y_s, paddle_l_top, PAD_LEN)) begin
                step_dx_neg_s = 1'b0;
                step_x_s      = x_q + 6'd1;
            end else begin
                miss_l_s = 1'b1;
            end
        end else if (!dx_neg_q && (x_q == R_HIT_X)) begin
            if (paddle_covers(step_y_s, paddle_r_top, PAD_LEN)) begin
                step_dx_neg_s = 1'b1;
                step_x_s      = x_q - 6'd1;
            end else begin
                miss_r_s = 1'b1;
            end
        end else begin
            step_dx_neg_s = dx_neg_q;
        end
    end

    assign win_reached_s = (score_l_q == WIN) || (score_r_q == WIN);

    // Game FSM and ball/score registers; everything advances only on a frame tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            x_q          <= CENTRE_X;
            y_q          <= CENTRE_Y;
            dx_neg_q     <= 1'b0;
            dy_neg_q     <= 1'b0;
            serve_left_q <= 1'b0;
            score_l_q    <= 4'd0;
            score_r_q    <= 4'd0;
        end else if (frame_tick_s) begin
            case (state_q)
                IDLE: begin
                    if (serve_btn) begin
                        state_q   <= SERVE;
                        score_l_q <= 4'd0;
                        score_r_q <= 4'd0;
                        x_q       <= CENTRE_X;
                        y_q       <= CENTRE_Y;
                        dx_neg_q  <= serve_left_q;
                        dy_neg_q  <= 1'b0;
                    end
                end
                SERVE: begin
                    x_q      <= CENTRE_X;
                    y_q      <= CENTRE_Y;
                    dx_neg_q <= serve_left_q;
                    dy_neg_q <= 1'b0;
                    if (hold_done_s) begin
                        state_q <= PLAY;
                    end
                end
                PLAY: begin
                    if (move_tick_s) begin
                        if (miss_l_s) begin
                            state_q      <= POINT;
                            serve_left_q <= 1'b1;
                            if (score_r_q != WIN) begin
                                score_r_q <= score_r_q + 4'd1;
                            end
                        end else if (miss_r_s) begin
                            state_q      <= POINT;
                            serve_left_q <= 1'b0;
                            if (score_l_q != WIN) begin
                                score_l_q <= score_l_q + 4'd1;
                            end
                        end else begin
                            x_q      <= step_x_s;
                            y_q      <= step_y_s;
                            dx_neg_q <= step_dx_neg_s;
                            dy_neg_q <= step_dy_neg_s;
                        end
                    end
                end
                POINT: begin
                    if (hold_done_s) begin
                        if (win_reached_s) begin
                            state_q <= GAMEOVER;
                        end else begin
                            state_q  <= SERVE;
                            x_q      <= CENTRE_X;
                            y_q      <= CENTRE_Y;
                            dx_neg_q <= serve_left_q;
                            dy_neg_q <= 1'b0;
                        end
                    end
                end
                GAMEOVER: begin
                    if (serve_btn) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign ball_x     = x_q;
    assign ball_y     = y_q;
    assign score_l    = score_l_q;
    assign score_r    = score_r_q;
    assign game_state = state_q;
    assign ball_on    = (hori_grid == x_q) && (vert_grid == y_q) &&
                        (state_q != IDLE) && (state_q != GAMEOVER);

endmodule

// File: tb/tb_pong_game_fsm.sv
// Randomised bench for pong_game_fsm: a frame-level game model predicts every frame,
// while paddle placement steers rallies toward chosen hits and misses.
module tb_pong_game_fsm;
    import pong_pkg::*;

    localparam int HOLD      = 60;
    localparam int SPEED     = 4;
    localparam int WIN_PTS   = 9;
    localparam int PLEN      = 4;
    localparam int LAST_ROW  = 29;
    localparam int LEFT_ADJ  = 1;
    localparam int RIGHT_ADJ = 38;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync;
    logic       serve_btn;
    logic [4:0] paddle_l_top;
    logic [4:0] paddle_r_top;
    logic [5:0] hori_grid;
    logic [4:0] vert_grid;
    logic [5:0] ball_x;
    logic [4:0] ball_y;
    logic       ball_on;
    logic [3:0] score_l;
    logic [3:0] score_r;
    logic [2:0] game_state;

    int checks = 0;
    int errors = 0;

    game_state_t m_state;
    int m_x, m_y, m_dx, m_dy, m_sl, m_sr, m_serve, m_cnt;

    pong_game_fsm dut (
        .clk          (clk),
        .reset        (reset),
        .vsync        (vsync),
        .serve_btn    (serve_btn),
        .paddle_l_top (paddle_l_top),
        .paddle_r_top (paddle_r_top),
        .hori_grid    (hori_grid),
        .vert_grid    (vert_grid),
        .ball_x       (ball_x),
        .ball_y       (ball_y),
        .ball_on      (ball_on),
        .score_l      (score_l),
        .score_r      (score_r),
        .game_state   (game_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_state = IDLE;
        m_x = 20; m_y = 15; m_dx = 1; m_dy = 1;
        m_sl = 0; m_sr = 0; m_serve = 1; m_cnt = 0;
    endtask

    task automatic model_park();
        m_x = 20; m_y = 15; m_dx = m_serve; m_dy = 1;
    endtask

    function automatic int predict_ny();
        int dy;
        dy = m_dy;
        if ((m_y == 0 && dy < 0) || (m_y == LAST_ROW && dy > 0)) dy = -dy;
        return m_y + dy;
    endfunction

    task automatic model_move(input int pl, input int pr);
        int dy, ny;
        dy = m_dy;
        if ((m_y == 0 && dy < 0) || (m_y == LAST_ROW && dy > 0)) dy = -dy;
        ny = m_y + dy;
        if (m_dx < 0 && m_x == LEFT_ADJ) begin
            if (ny >= pl && ny <= pl + PLEN - 1) begin
                m_dx = 1; m_x = m_x + 1; m_y = ny; m_dy = dy;
            end else begin
                m_state = POINT; m_cnt = 0; m_serve = -1;
                if (m_sr < WIN_PTS) m_sr++;
            end
        end else if (m_dx > 0 && m_x == RIGHT_ADJ) begin
            if (ny >= pr && ny <= pr + PLEN - 1) begin
                m_dx = -1; m_x = m_x - 1; m_y = ny; m_dy = dy;
            end else begin
                m_state = POINT; m_cnt = 0; m_serve = 1;
                if (m_sl < WIN_PTS) m_sl++;
            end
        end else begin
            m_x = m_x + m_dx; m_y = ny; m_dy = dy;
        end
    endtask

    task automatic model_tick(input bit btn, input int pl, input int pr);
        case (m_state)
            IDLE: if (btn) begin
                m_state = SERVE; m_sl = 0; m_sr = 0; m_cnt = 0; model_park();
            end
            SERVE: begin
                m_cnt++;
                if (m_cnt == HOLD) begin m_state = PLAY; m_cnt = 0; end
            end
            PLAY: begin
                m_cnt++;
                if (m_cnt % SPEED == 0) model_move(pl, pr);
            end
            POINT: begin
                m_cnt++;
                if (m_cnt == HOLD) begin
                    m_cnt = 0;
                    if (m_sl == WIN_PTS || m_sr == WIN_PTS) m_state = GAMEOVER;
                    else begin m_state = SERVE; model_park(); end
                end
            end
            GAMEOVER: if (btn) m_state = IDLE;
            default: m_state = IDLE;
        endcase
    endtask

    task automatic compare_all(input string ph);
        bit exp_on;
        check({ph, "_state"}, 32'(game_state), 32'(m_state));
        check({ph, "_x"}, 32'(ball_x), 32'(m_x));
        check({ph, "_y"}, 32'(ball_y), 32'(m_y));
        check({ph, "_score_l"}, 32'(score_l), 32'(m_sl));
        check({ph, "_score_r"}, 32'(score_r), 32'(m_sr));
        exp_on = (m_state != IDLE) && (m_state != GAMEOVER);
        hori_grid = 6'(m_x); vert_grid = 5'(m_y);
        #1;
        check({ph, "_ball_on"}, 32'(ball_on), 32'(exp_on));
        hori_grid = 6'(m_x + 1);
        #1;
        check({ph, "_ball_off"}, 32'(ball_on), 32'd0);
    endtask

    // One vsync frame: inputs held stable across the tick, then model and DUT compared.
    task automatic frame(input bit btn, input int pl, input int pr);
        serve_btn = btn;
        paddle_l_top = 5'(pl);
        paddle_r_top = 5'(pr);
        vsync = 1'b0;
        repeat (3) @(negedge clk);
        vsync = 1'b1;
        repeat (2) @(negedge clk);
        model_tick(btn, pl, pr);
        compare_all("frame");
    endtask

    function automatic int pick_top(input bit hit, input int ny);
        int t;
        if (hit) begin
            t = ny - int'($urandom_range(3, 0));
            if (t < 0) t = 0;
            return t;
        end
        if (ny >= 15) return int'($urandom_range(ny - 4, 0));
        return int'($urandom_range(31, ny + 1));
    endfunction

    task automatic play_frame(input bit l_hit, input bit r_hit);
        int ny;
        ny = predict_ny();
        frame(1'($urandom_range(1, 0)), pick_top(l_hit, ny), pick_top(r_hit, ny));
    endtask

    initial begin
        int n;
        reset = 1'b0; vsync = 1'b1; serve_btn = 1'b0;
        paddle_l_top = 5'd0; paddle_r_top = 5'd0; hori_grid = 6'd0; vert_grid = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all("reset");
        reset = 1'b1;
        @(negedge clk);

        repeat (3) frame(1'b0, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        check("idle_hold", 32'(game_state), 32'(IDLE));
        frame(1'b1, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        check("serve_entry", 32'(game_state), 32'(SERVE));
        repeat (HOLD - 1) play_frame(1'b1, 1'b1);
        check("serve_still", 32'(game_state), 32'(SERVE));
        play_frame(1'b1, 1'b1);
        check("play_entry", 32'(game_state), 32'(PLAY));
        repeat (SPEED - 1) play_frame(1'b1, 1'b1);
        check("pre_step_x", 32'(ball_x), 32'd20);
        play_frame(1'b1, 1'b1);
        check("first_step_x", 32'(ball_x), 32'd21);
        check("first_step_y", 32'(ball_y), 32'd16);

        // Rally: right paddle returns, left paddle misses.
        n = 0;
        while (m_state == PLAY && n < 400) begin play_frame(1'b0, 1'b1); n++; end
        check("miss_state", 32'(game_state), 32'(POINT));
        check("miss_score_r", 32'(score_r), 32'd1);
        check("miss_score_l", 32'(score_l), 32'd0);
        repeat (2 * HOLD) play_frame(1'b1, 1'b1);
        check("reserve_play", 32'(game_state), 32'(PLAY));
        repeat (SPEED) play_frame(1'b1, 1'b1);
        check("serve_left_x", 32'(ball_x), 32'd19);
        check("serve_left_y", 32'(ball_y), 32'd16);
        repeat (5) play_frame(1'b1, 1'b1);

        // Asynchronous reset in the middle of play.
        #2 reset = 1'b0;
        #1;
        check("async_rst_state", 32'(game_state), 32'(IDLE));
        check("async_rst_x", 32'(ball_x), 32'd20);
        check("async_rst_y", 32'(ball_y), 32'd15);
        check("async_rst_score_r", 32'(score_r), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        @(negedge clk);

        // Left always returns, right always misses, until the left player wins.
        frame(1'b1, int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        n = 0;
        while (m_state != GAMEOVER && n < 3000) begin play_frame(1'b1, 1'b0); n++; end
        check("win_state", 32'(game_state), 32'(GAMEOVER));
        check("win_score_l", 32'(score_l), 32'd9);
        check("win_score_r", 32'(score_r), 32'd0);
        hori_grid = ball_x; vert_grid = ball_y;
        #1;
        check("gameover_hidden", 32'(ball_on), 32'd0);

        // serve_btn held: GAMEOVER -> IDLE, and only the following tick starts a game.
        frame(1'b1, 0, 0);
        check("held_idle", 32'(game_state), 32'(IDLE));
        frame(1'b1, 0, 0);
        check("held_serve", 32'(game_state), 32'(SERVE));
        check("new_game_score_l", 32'(score_l), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
